// File: rtl/circuit_with_udp_02467_core.sv
`default_nettype none
// ============================================================================
// Module      : circuit_with_udp_02467_core
// Description : Registered 3-input truth-table lookup with a gated copy.
//               E is the table bit selected by {A,B,C}, F is that bit ANDed
//               with D. Both outputs are registered, with one cycle of
//               latency, and are cleared asynchronously by rst.
// Ports       : clk - system clock, rising edge active
//               rst - asynchronous active-high reset
//               E   - registered TRUTH_TABLE[{A,B,C}]
//               F   - registered TRUTH_TABLE[{A,B,C}] & D
//               A   - table index bit 2 (MSB)
//               B   - table index bit 1
//               C   - table index bit 0 (LSB)
//               D   - gating input for F
// Parameters  : TRUTH_TABLE - bit i is the E value for index {A,B,C} = i.
//               The default 8'hD5 selects minterms 0,2,4,6,7.
// Revision    : 1.0 - initial release
// ============================================================================
module circuit_with_udp_02467_core #(
   parameter logic [7:0] TRUTH_TABLE = 8'hD5
) (
   input  logic clk,
   input  logic rst,
   output logic E,
   output logic F,
   input  logic A,
   input  logic B,
   input  logic C,
   input  logic D
);

   logic [2:0] w_index;
   logic       w_e_next;
   logic       w_f_next;
   logic       r_e;
   logic       r_f;

   assign w_index  = {A, B, C};
   // An unknown index bit selects X in 4-state simulation. The AND with D
   // keeps F at a known 0 whenever the selected table bit is 0.
   assign w_e_next = TRUTH_TABLE[w_index];
   assign w_f_next = w_e_next & D;

   // The reset is applied and released directly at the flops. Clearing
   // happens without a clock edge. After release the first rising edge
   // performs the first load, and any sample pending when reset arrives
   // is discarded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_e <= 1'b0;
         r_f <= 1'b0;
      end else begin
         r_e <= w_e_next;
         r_f <= w_f_next;
      end
   end

   assign E = r_e;
   assign F = r_f;

endmodule
`default_nettype wire

// File: tb/tb_circuit_with_udp_02467_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_circuit_with_udp_02467_core
// Description : Scoreboard bench for circuit_with_udp_02467_core. It drives
//               the same inputs into two instances: one with the default
//               table and one with TRUTH_TABLE = 8'h01. The stimulus pushes
//               the expected outputs, and the monitor pops and compares them
//               after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_circuit_with_udp_02467_core;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
   logic e0, f0, e1, f1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit       e0;
      bit       f0;
      bit       e1;
      bit       f1;
      bit [3:0] code;
   } exp_t;

   exp_t q[$];

   // Default-table mapping written out row by row, indexed by {A,B,C}.
   bit e_map [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

   circuit_with_udp_02467_core dut0 (
      .clk(clk), .rst(rst), .E(e0), .F(f0), .A(a), .B(b), .C(c), .D(d)
   );

   circuit_with_udp_02467_core #(.TRUTH_TABLE(8'h01)) dut1 (
      .clk(clk), .rst(rst), .E(e1), .F(f1), .A(a), .B(b), .C(c), .D(d)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic act, input bit exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the default table is taken from the row listing, and
   // the override table 8'h01 is true only for index 000.
   // F is true when the table bit and D are both 1.
   task automatic apply(input bit [3:0] code);
      exp_t x;
      int   idx;
      {a, b, c, d} = code;
      idx  = code[3:1];
      x.e0 = e_map[idx];
      x.f0 = e_map[idx] && code[0];
      x.e1 = (idx == 0);
      x.f1 = (idx == 0) && code[0];
      x.code = code;
      q.push_back(x);
   endtask

   task automatic drive(input bit [3:0] code);
      @(negedge clk);
      apply(code);
   endtask

   // Monitor: after each rising edge, check the oldest expected sample.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            x = q.pop_front();
            chk($sformatf("E_default code=%b", x.code), e0, x.e0);
            chk($sformatf("F_default code=%b", x.code), f0, x.f0);
            chk($sformatf("E_override code=%b", x.code), e1, x.e1);
            chk($sformatf("F_override code=%b", x.code), f1, x.f1);
         end
      end
   end

   initial begin
      int waited;
      // Asynchronous reset before any clock edge.
      {a, b, c, d} = 4'($urandom);
      #1 rst = 1'b1;
      #1;
      chk("reset_async_E", e0, 1'b0);
      chk("reset_async_F", f0, 1'b0);

      // Outputs hold 0 through clock edges while reset is high.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         {a, b, c, d} = 4'($urandom);
         @(posedge clk);
         #1;
         chk("reset_hold_E", e0, 1'b0);
         chk("reset_hold_F", f0, 1'b0);
         chk("reset_hold_E1", e1, 1'b0);
      end

      // Release reset, then sweep all 16 codes starting at the next edge.
      @(negedge clk);
      rst = 1'b0;
      apply(4'd0);
      for (int i = 1; i < 16; i++) drive(4'(i));

      // Hold ABCD=1110, then raise D.
      drive(4'b1110);
      drive(4'b1110);
      drive(4'b1111);
      drive(4'b1111);

      // Randomized traffic.
      for (int i = 0; i < 200; i++) drive(4'($urandom));

      // An input change between edges must not reach the outputs.
      drive(4'b0010);
      @(posedge clk);
      #3;
      {a, b, c, d} = 4'b1111;
      #1;
      chk("midcycle_E", e0, 1'b0);
      chk("midcycle_F", f0, 1'b0);
      @(negedge clk);
      apply(4'b1111);

      // Load 1111, reset between edges, then reload after release.
      drive(4'b1111);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("midop_reset_E", e0, 1'b0);
      chk("midop_reset_F", f0, 1'b0);
      @(posedge clk);
      #1;
      chk("midop_reset_hold_E", e0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      apply(4'b1111);
      drive(4'b0001);
      drive(4'b0011);

      // Let the scoreboard drain within a bounded number of cycles.
      waited = 0;
      while (q.size() > 0 && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d entries left expected 0", q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
